// File: rtl/arcade_input_cond.sv
// arcade_input_cond
//   Sits between the control mapping and the core's active-low INP bus.
//   Every raw control bit is synchronised into clk_sys and debounced on a
//   slow tick. Coin bits are then shaped into fixed-width pulses followed by a
//   lockout gap, and each accepted coin is counted for diagnostics.
//
// Ports
//   clk_sys     in   system clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   1 = normal, 0 = all controls inactive, coin FSMs held idle
//   raw_in      in   [NUM_IN] active-high raw controls (asynchronous)
//   inp_n       out  [NUM_IN] conditioned controls, active-low, registered
//   coin_pulse  out  [2] one-cycle strobe per accepted coin
//   coin_cnt0   out  [8] accepted coins on coin 0 (lowest COIN_MASK bit), wraps
//   coin_cnt1   out  [8] accepted coins on coin 1, wraps
//   coin_state  out  [4] debug view of the coin FSMs, {coin1, coin0}

module arcade_input_cond #(
    parameter int                NUM_IN     = 11,
    parameter logic [NUM_IN-1:0] COIN_MASK  = 11'h300,
    parameter int                TICK_DIV   = 4800,
    parameter int                DB_TICKS   = 10,
    parameter int                COIN_TICKS = 500,
    parameter int                COIN_GAP   = 200
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_IN-1:0] raw_in,
    output logic [NUM_IN-1:0] inp_n,
    output logic [1:0]        coin_pulse,
    output logic [7:0]        coin_cnt0,
    output logic [7:0]        coin_cnt1,
    output logic [3:0]        coin_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } coin_state_t;

    // Position of the n-th set bit of COIN_MASK, or -1 when there is none.
    function automatic int coin_bit(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (COIN_MASK[i]) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    localparam int COIN_IDX0 = coin_bit(0);
    localparam int COIN_IDX1 = coin_bit(1);
    localparam bit HAS0      = (COIN_IDX0 >= 0);
    localparam bit HAS1      = (COIN_IDX1 >= 0);
    // In-range stand-ins so absent coins never produce an out-of-range select.
    localparam int SAFE0     = HAS0 ? COIN_IDX0 : 0;
    localparam int SAFE1     = HAS1 ? COIN_IDX1 : 0;

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW   = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int TMAX = (COIN_TICKS > COIN_GAP) ? COIN_TICKS : COIN_GAP;
    localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] sync1;
    logic [NUM_IN-1:0] sync2;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce tick prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce: stable flips only after DB_TICKS consecutive ticks on which
    // the synchronised input disagreed with it. Runs regardless of enable.
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] stable;
    logic [DW-1:0]     db_cnt [NUM_IN];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < NUM_IN; i++) db_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DW'(DB_TICKS - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Coin shaping, one FSM per coin bit
    // ------------------------------------------------------------------
    logic [1:0]      coin_active;
    logic [1:0]      pulse_w;
    logic [1:0][7:0] cnt_w;

    for (genvar k = 0; k < 2; k++) begin : g_coin
        localparam int IDX = (k == 0) ? SAFE0 : SAFE1;
        localparam bit HAS = (k == 0) ? HAS0 : HAS1;

        if (HAS) begin : g_fsm
            coin_state_t   st;
            logic [TW-1:0] tcnt;
            logic          prev_q;
            logic          pulse_q;
            logic [7:0]    cnt_q;
            logic          coin_s;
            logic          coin_rise;

            assign coin_s    = stable[IDX];
            assign coin_rise = coin_s & ~prev_q;

            // prev_q tracks stable even while disabled, so a coin that became
            // stable-high during enable low shows no edge once enabled.
            // Timers count down on ticks and leave the state on the tick that
            // would take them to zero; the entry cycle never consumes a tick.
            always_ff @(posedge clk_sys or negedge rst_n) begin
                if (!rst_n) begin
                    st      <= ST_IDLE;
                    tcnt    <= '0;
                    prev_q  <= 1'b0;
                    pulse_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    prev_q  <= coin_s;
                    pulse_q <= 1'b0;
                    if (!enable) begin
                        st   <= ST_IDLE;
                        tcnt <= '0;
                    end else begin
                        case (st)
                            ST_IDLE: begin
                                if (coin_rise) begin
                                    st      <= ST_ACTIVE;
                                    tcnt    <= TW'(COIN_TICKS);
                                    pulse_q <= 1'b1;
                                    cnt_q   <= cnt_q + 8'd1;
                                end
                            end
                            ST_ACTIVE: begin
                                if (tick) begin
                                    if (tcnt <= TW'(1)) begin
                                        if (coin_s) begin
                                            st <= ST_RELEASE;
                                        end else begin
                                            st   <= ST_GAP;
                                            tcnt <= TW'(COIN_GAP);
                                        end
                                    end else begin
                                        tcnt <= tcnt - TW'(1);
                                    end
                                end
                            end
                            ST_RELEASE: begin
                                if (!coin_s) begin
                                    st   <= ST_GAP;
                                    tcnt <= TW'(COIN_GAP);
                                end
                            end
                            ST_GAP: begin
                                if (tick) begin
                                    if (tcnt <= TW'(1)) begin
                                        st <= ST_IDLE;
                                    end else begin
                                        tcnt <= tcnt - TW'(1);
                                    end
                                end
                            end
                            default: st <= ST_IDLE;
                        endcase
                    end
                end
            end

            assign coin_active[k]       = (st == ST_ACTIVE);
            assign pulse_w[k]           = pulse_q;
            assign cnt_w[k]             = cnt_q;
            assign coin_state[2*k +: 2] = st;
        end else begin : g_none
            assign coin_active[k]       = 1'b0;
            assign pulse_w[k]           = 1'b0;
            assign cnt_w[k]             = 8'd0;
            assign coin_state[2*k +: 2] = 2'b00;
        end
    end

    assign coin_pulse = pulse_w;
    assign coin_cnt0  = cnt_w[0];
    assign coin_cnt1  = cnt_w[1];

    // ------------------------------------------------------------------
    // Active-low output bus: plain bits follow stable, coin bits follow
    // their FSM's ACTIVE state.
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] inp_n_next;

    always_comb begin
        inp_n_next = ~(stable & {NUM_IN{enable}});
        if (HAS0) inp_n_next[SAFE0] = ~(coin_active[0] & enable);
        if (HAS1) inp_n_next[SAFE1] = ~(coin_active[1] & enable);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            inp_n <= '1;
        end else begin
            inp_n <= inp_n_next;
        end
    end

endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Input conditioner between the control mapping (keyboard / USB / DB15 merge plus 4-way filter) and the game core's active-low INP bus.
- Synchronises and debounces every active-high control bit.
- Shapes coin inputs into fixed-width pulses with a lockout gap, counts coins for diagnostics, and drives the inverted bus the core samples.

Parameters:
- NUM_IN, 11, number of control bits (bit order = core INP order).
- COIN_MASK, 11'h300, bits treated as coin inputs (default bits 8 and 9); at most 2 bits set.
- TICK_DIV, 4800, clk_sys cycles per debounce tick (100 us at 48 MHz).
- DB_TICKS, 10, consecutive ticks an input must differ from its stable value before the stable value flips.
- COIN_TICKS, 500, ticks a coin output stays asserted (50 ms).
- COIN_GAP, 200, ticks of lockout after coin release before a new coin is accepted.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  high = normal; low = outputs forced inactive (driven from ~ioctl_download).
- raw_in  in  NUM_IN  active-high raw controls, asynchronous to clk_sys.
- inp_n  out  NUM_IN  conditioned controls, active-low, registered.
- coin_pulse  out  2  one-cycle strobe per accepted coin; index 0 = lowest set COIN_MASK bit.
- coin_cnt0  out  8  accepted-coin count for coin 0, wraps.
- coin_cnt1  out  8  accepted-coin count for coin 1, wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - inp_n = all ones; coin_pulse = 0; coin_cnt0/1 = 0.
  - Synchronisers, stable values, debounce counters and prescaler cleared; coin FSMs in IDLE.
- Release is synchronous: the first cycle after rst_n rises is prescaler count 0.
- Synchroniser: 2-flop per bit. Added latency: 2 cycles.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick = 1 for one cycle when count = TICK_DIV-1, then count wraps to 0.
- Debounce, per bit, evaluated only on a tick:
  - If sync != stable, increment db_cnt.
  - If sync == stable, clear db_cnt.
  - When db_cnt reaches DB_TICKS-1 while still differing, stable <= sync and db_cnt <= 0.
  - A glitch shorter than DB_TICKS ticks never changes stable.
  - Worst-case latency from a clean edge to a stable change: 2 + DB_TICKS*TICK_DIV cycles.
- Non-coin bits: inp_n[i] <= ~(stable[i] & enable), registered, 1 cycle after the stable change.
- Coin FSM, one per coin bit:
  - IDLE: on a rising edge of stable coin, go to ACTIVE, load tcnt = COIN_TICKS, pulse coin_pulse for 1 cycle, increment coin_cntN (255 -> 0).
  - ACTIVE: coin output asserted; decrement tcnt each tick. At tcnt = 0, go to RELEASE if stable coin = 1, else load tcnt = COIN_GAP and go to GAP.
  - RELEASE: wait for stable coin = 0, then load COIN_GAP and go to GAP.
  - GAP: decrement on ticks; at 0 go to IDLE.
  - Rising edges seen in ACTIVE, RELEASE or GAP are ignored and not counted.
  - Pulse width is fixed at COIN_TICKS ticks regardless of how long the raw coin is held.
  - Coin already high when leaving reset: stable rises after debounce, which counts as an edge, so one coin is accepted.
- inp_n for coin bits = ~(fsm == ACTIVE & enable).
- Two coins rising on the same cycle: both accepted independently, both strobes asserted together.
- enable low:
  - inp_n all ones, coin_pulse = 0.
  - Coin FSMs forced to IDLE; debounce logic keeps running.
  - A coin already stable-high when enable rises is not accepted until it is released and pressed again; IDLE needs a 0->1 edge seen while enabled.
- tick and a stable edge on the same cycle: the edge is handled, and the tick decrement applies from the next tick only.

Test Plan (TICK_DIV=4, DB_TICKS=3, COIN_TICKS=5, COIN_GAP=2):
- Reset: pulse rst_n low mid-run with raw_in = 11'h7FF -> inp_n = 11'h7FF immediately; coin_cnt0/1 = 0.
- Debounce: raw_in[0] high for 8 cycles, then low -> inp_n[0] stays 1. Held high -> inp_n[0] = 0 within 2+12+1 = 15 cycles.
- Coin shape: raw_in[8] held high 200 cycles -> inp_n[8] low for exactly 20 cycles (±3); coin_pulse[0] is a single one-cycle strobe; coin_cnt0 = 1.
- Lockout: second coin press starting 1 tick after release -> ignored, coin_cnt0 stays 1. A press after GAP ends -> coin_cnt0 = 2.
- Simultaneous / wrap: 256 clean presses on both coins together -> both strobes coincide every time; coin_cnt0 = coin_cnt1 = 0 after wrap.
- Enable: hold coin high while enable = 0, then raise enable -> no pulse and count unchanged; release then press -> one coin accepted.
